// File: rtl/not_gate_pkg.sv
// not_gate_pkg: width limit and style encoding shared by the not_gate_unit slice.
package not_gate_pkg;
  localparam int NOT_GATE_MAX_WIDTH = 64;
  typedef enum logic [1:0] {STYLE_DF = 2'd0, STYLE_BH = 2'd1, STYLE_ST = 2'd2} not_style_e;
endpackage

// File: rtl/not_bit_st.sv
// not_bit_st: one-bit structural inverter built from a single gate primitive.
module not_bit_st (
  input  logic a,
  output logic b
);
  not u_not (b, a);
endmodule

// File: rtl/not_gate_unit.sv
// not_gate_unit: bitwise inverter (dataflow/behavioural/structural) with registered copy.
// NOT_GATE_XCHECK_EN builds all three styles and flags any disagreement on mismatch.
module not_gate_unit
  import not_gate_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int STYLE_SEL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic             valid_in,
  output logic [WIDTH-1:0] b_comb,
  output logic [WIDTH-1:0] b,
  output logic             valid_out,
  output logic             mismatch
);
  logic [WIDTH-1:0] b_df, b_bh, b_st, b_sel, b_d, b_q;
  logic valid_d, valid_q;
`ifdef NOT_GATE_XCHECK_EN
  localparam bit XCHECK = 1'b1;
`else
  localparam bit XCHECK = 1'b0;
`endif
  if (STYLE_SEL < 0 || STYLE_SEL > 2) begin : g_bad_style
    $error("not_gate_unit: illegal STYLE_SEL %0d", STYLE_SEL);
  end
  if (WIDTH < 1 || WIDTH > NOT_GATE_MAX_WIDTH) begin : g_bad_width
    $error("not_gate_unit: illegal WIDTH %0d", WIDTH);
  end
  // Styles not needed for output or cross-check are tied off instead of built.
  if (XCHECK || STYLE_SEL == int'(STYLE_DF)) begin : g_df
    assign b_df = ~a;
  end else begin : g_df_off
    assign b_df = '0;
  end
  if (XCHECK || STYLE_SEL == int'(STYLE_BH)) begin : g_bh
    always_comb begin
      b_bh = '0;
      for (int i = 0; i < WIDTH; i++) b_bh[i] = ~a[i];
    end
  end else begin : g_bh_off
    assign b_bh = '0;
  end
  if (XCHECK || STYLE_SEL == int'(STYLE_ST)) begin : g_st
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      not_bit_st u_bit (.a(a[i]), .b(b_st[i]));
    end
  end else begin : g_st_off
    assign b_st = '0;
  end
  always_comb begin
    b_sel   = STYLE_SEL == int'(STYLE_ST) ? b_st : STYLE_SEL == int'(STYLE_BH) ? b_bh : b_df;
    b_d     = valid_in ? b_sel : b_q;
    valid_d = valid_in;
  end
  always_ff @(posedge clk) begin
    b_q     <= rst ? '0 : b_d;
    valid_q <= rst ? 1'b0 : valid_d;
  end
  assign b_comb    = b_sel;
  assign b         = b_q;
  assign valid_out = valid_q;
`ifdef NOT_GATE_XCHECK_EN
  logic mismatch_d, mismatch_q;
  always_comb mismatch_d = mismatch_q | (b_df != b_bh) | (b_df != b_st);
  always_ff @(posedge clk) mismatch_q <= rst ? 1'b0 : mismatch_d;
  assign mismatch = mismatch_q;
  always_ff @(posedge clk)
    if (!rst) assert (b_df == b_bh && b_df == b_st) else $error("not_gate_unit: style disagreement");
`else
  assign mismatch = 1'b0;
`endif
endmodule

// File: tb/tb_not_gate_unit.sv
// tb_not_gate_unit: directed scoreboard bench for not_gate_unit (WIDTH 1 and 8).
module tb_not_gate_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid_in = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b_comb, b, b_comb_s, b_s;
  logic valid_out, mismatch, vo_s, mm_s;
  logic a1 = 1'b0;
  logic [2:0] bc1, bq1, vo1, mm1;
  logic [8:0] sb[$];
  logic [8:0] e;
  logic [7:0] exp_b = '0;
  logic exp_v = 1'b0;
  logic exp_mm = 1'b0;
  int total = 0;
  int passed = 0;
  always #5 clk = ~clk;
  not_gate_unit #(.WIDTH(8), .STYLE_SEL(0)) u8 (
    .clk(clk), .rst(rst), .a(a), .valid_in(valid_in),
    .b_comb(b_comb), .b(b), .valid_out(valid_out), .mismatch(mismatch));
  not_gate_unit #(.WIDTH(8), .STYLE_SEL(2)) u8s (
    .clk(clk), .rst(rst), .a(a), .valid_in(valid_in),
    .b_comb(b_comb_s), .b(b_s), .valid_out(vo_s), .mismatch(mm_s));
  for (genvar s = 0; s < 3; s++) begin : g_w1
    not_gate_unit #(.WIDTH(1), .STYLE_SEL(s)) u1 (
      .clk(clk), .rst(rst), .a(a1), .valid_in(valid_in),
      .b_comb(bc1[s]), .b(bq1[s]), .valid_out(vo1[s]), .mismatch(mm1[s]));
  end
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask
  task automatic step(input logic r, input logic v, input logic [7:0] x, input logic forced);
    @(negedge clk);
    rst = r;
    valid_in = v;
    a = x;
    #1;
    chk("b_comb", b_comb, ~x);
    chk("b_comb_st", b_comb_s, ~x);
    if (r) begin
      exp_b = '0;
      exp_v = 1'b0;
      exp_mm = 1'b0;
    end else begin
      exp_v = v;
      if (v) exp_b = ~x;
      exp_mm = exp_mm | forced;
    end
    sb.push_back({exp_v, exp_b});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("b", b, e[7:0]);
    chk("valid_out", {7'd0, valid_out}, {7'd0, e[8]});
    chk("b_st", b_s, e[7:0]);
    chk("mismatch", {7'd0, mismatch}, {7'd0, exp_mm});
  endtask
  initial begin
    a1 = 1'b0;
    #10;
    for (int s = 0; s < 3; s++) chk($sformatf("w1_a0_style%0d", s), {7'd0, bc1[s]}, 8'd1);
    a1 = 1'b1;
    #10;
    for (int s = 0; s < 3; s++) chk($sformatf("w1_a1_style%0d", s), {7'd0, bc1[s]}, 8'd0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'hA5, 1'b0);
    step(1'b0, 1'b0, 8'hFF, 1'b0);
    step(1'b1, 1'b1, 8'h0F, 1'b0);
    step(1'b0, 1'b1, 8'h3C, 1'b0);
    step(1'b0, 1'b0, 8'h81, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
    for (int i = 0; i < 256; i++) step(1'b0, i[0], 8'(i), 1'b0);
`ifdef NOT_GATE_XCHECK_EN
    force u8.b_bh = 8'h00;
    step(1'b0, 1'b1, 8'h00, 1'b1);
    release u8.b_bh;
    step(1'b0, 1'b1, 8'h12, 1'b0);
    step(1'b0, 1'b0, 8'h34, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h56, 1'b0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
